// File: rtl/io_ctrl_pkg.sv
// Shared types and helpers for the OTTER board I/O control block (io_mode_ctrl).
package io_ctrl_pkg;

    typedef enum logic {
        IDLE,
        PENDING
    } mode_state_t;

    typedef enum logic [1:0] {
        HOLD_CALIB,
        HOLD_COUNT,
        RUN
    } rst_state_t;

    // Bits needed for a counter that must hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/io_mode_ctrl_debounce_channel.sv
// One push-button channel: 2-flop synchroniser, stability counter, rising-edge pulse.
// Defining DEBOUNCE_BYPASS_EN drops the counter and passes the synchronised level through.
module debounce_channel
    import io_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic db,
    output logic pulse
);

    logic [1:0] sync;
    logic       db_d;

    // NOTE: every flop here uses non-blocking assignment so the chain shifts one stage per edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync  <= '0;
            db_d  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            db_d  <= db;
            pulse <= db & ~db_d;
        end
    end

`ifdef DEBOUNCE_BYPASS_EN
    assign db = sync[1];
`else
    localparam int CW = cnt_width(DB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          db_q;

    // Any disagreement that does not last DB_CYCLES cycles is discarded.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            db_q <= 1'b0;
        end else if (sync[1] == db_q) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            db_q <= ~db_q;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign db = db_q;
`endif

endmodule

// File: rtl/io_mode_ctrl.sv
// OTTER board control: button debounce, MCU reset sequencing and idle-safe UART mode routing.
// Build option: DEBOUNCE_BYPASS_EN (see debounce_channel).
module io_mode_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int NUM_BTNS     = 4,
    parameter int DB_CYCLES    = 500000,
    parameter int NUM_MODES    = 2,
    parameter int MODE_BTN_IDX = 0,
    parameter int RST_BTN_IDX  = 1,
    parameter int RST_HOLD     = 16,
    parameter int IDLE_CYCLES  = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_BTNS-1:0]          BTN,
    input  logic                         init_calib_complete,
    input  logic                         srx,
    output logic                         stx,
    input  logic [NUM_MODES-1:0]         tx_in,
    output logic [NUM_MODES-1:0]         rx_out,
    output logic [NUM_BTNS-1:0]          DB_BTN,
    output logic [NUM_BTNS-1:0]          BTN_PULSE,
    output logic [$clog2(NUM_MODES)-1:0] MODE,
    output logic                         MODE_PENDING,
    output logic                         CPU_RESET
);

    localparam int MW = $clog2(NUM_MODES);
    localparam int IW = cnt_width(IDLE_CYCLES);
    localparam int HW = cnt_width(RST_HOLD);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db (
            .CLK   (CLK),
            .RST   (RST),
            .btn   (BTN[g]),
            .db    (DB_BTN[g]),
            .pulse (BTN_PULSE[g])
        );
    end

    assign stx = tx_in[MODE];

    // NOTE: rx_out gets a full default before the indexed write so no latch is inferred.
    always_comb begin
        rx_out       = '1;
        rx_out[MODE] = srx;
    end

    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] m);
        return (m == MW'(NUM_MODES - 1)) ? '0 : m + 1'b1;
    endfunction

    mode_state_t   mode_state;
    logic [MW-1:0] target;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic          mode_press;
    logic          apply;

    always_comb begin
        idle_next = '0;
        if (tx_in[MODE])
            idle_next = (idle_cnt == IW'(IDLE_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
    end

    assign mode_press = BTN_PULSE[MODE_BTN_IDX];
    assign apply      = (mode_state == PENDING) && (idle_next == IW'(IDLE_CYCLES));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_state   <= IDLE;
            MODE         <= '0;
            target       <= '0;
            idle_cnt     <= '0;
            MODE_PENDING <= 1'b0;
        end else begin
            idle_cnt <= apply ? '0 : idle_next;
            if (apply) begin
                MODE <= target;
                // A press coinciding with the switch opens a fresh request from the new mode.
                if (mode_press) begin
                    target       <= wrap_inc(target);
                    mode_state   <= PENDING;
                    MODE_PENDING <= 1'b1;
                end else begin
                    mode_state   <= IDLE;
                    MODE_PENDING <= 1'b0;
                end
            end else if (mode_press) begin
                target       <= (mode_state == IDLE) ? wrap_inc(MODE) : wrap_inc(target);
                mode_state   <= PENDING;
                MODE_PENDING <= 1'b1;
            end
        end
    end

    rst_state_t    rst_state;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_state <= HOLD_CALIB;
            hold_cnt  <= '0;
            CPU_RESET <= 1'b1;
        end else if (!init_calib_complete) begin
            rst_state <= HOLD_CALIB;
            CPU_RESET <= 1'b1;
        end else begin
            case (rst_state)
                HOLD_CALIB: begin
                    rst_state <= HOLD_COUNT;
                    hold_cnt  <= HW'(RST_HOLD);
                    CPU_RESET <= 1'b1;
                end
                HOLD_COUNT: begin
                    if (hold_cnt == '0) begin
                        rst_state <= RUN;
                        CPU_RESET <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (BTN_PULSE[RST_BTN_IDX]) begin
                        rst_state <= HOLD_COUNT;
                        hold_cnt  <= HW'(RST_HOLD);
                        CPU_RESET <= 1'b1;
                    end
                end
                default: begin
                    rst_state <= HOLD_CALIB;
                    CPU_RESET <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_mode_ctrl.sv
// Directed bench for io_mode_ctrl with a scoreboard queue of expected values.
module tb_io_mode_ctrl;

    localparam int NUM_BTNS    = 4;
    localparam int DB_CYCLES   = 8;
    localparam int NUM_MODES   = 3;
    localparam int RST_HOLD    = 16;
    localparam int IDLE_CYCLES = 32;
`ifdef DEBOUNCE_BYPASS_EN
    localparam int DB_LAT  = 2;
    localparam int BOUNCES = 0;
`else
    localparam int DB_LAT  = DB_CYCLES + 2;
    localparam int BOUNCES = 4;
`endif

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NUM_BTNS-1:0]  BTN;
    logic                 init_calib_complete;
    logic                 srx;
    logic                 stx;
    logic [NUM_MODES-1:0] tx_in;
    logic [NUM_MODES-1:0] rx_out;
    logic [NUM_BTNS-1:0]  DB_BTN;
    logic [NUM_BTNS-1:0]  BTN_PULSE;
    logic [1:0]           MODE;
    logic                 MODE_PENDING;
    logic                 CPU_RESET;

    always #5 CLK = ~CLK;

    io_mode_ctrl #(
        .NUM_BTNS     (NUM_BTNS),
        .DB_CYCLES    (DB_CYCLES),
        .NUM_MODES    (NUM_MODES),
        .MODE_BTN_IDX (0),
        .RST_BTN_IDX  (1),
        .RST_HOLD     (RST_HOLD),
        .IDLE_CYCLES  (IDLE_CYCLES)
    ) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .BTN                 (BTN),
        .init_calib_complete (init_calib_complete),
        .srx                 (srx),
        .stx                 (stx),
        .tx_in               (tx_in),
        .rx_out              (rx_out),
        .DB_BTN              (DB_BTN),
        .BTN_PULSE           (BTN_PULSE),
        .MODE                (MODE),
        .MODE_PENDING        (MODE_PENDING),
        .CPU_RESET           (CPU_RESET)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [NUM_MODES-1:0] rx_model(input int m, input logic s);
        logic [NUM_MODES-1:0] r;
        r    = '1;
        r[m] = s;
        return r;
    endfunction

    // Press and release the mode button, each level held long enough to debounce.
    task automatic press_mode();
        BTN[0] = 1'b1;
        tick(DB_LAT + 2);
        BTN[0] = 1'b0;
        tick(DB_LAT + 2);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int rise_at;
        int pulse_at;

        RST                 = 1'b1;
        BTN                 = '0;
        init_calib_complete = 1'b0;
        srx                 = 1'b1;
        tx_in               = '1;
        tick(3);

        expect_val("rst_db_btn", 0);        observe(32'(DB_BTN));
        expect_val("rst_btn_pulse", 0);     observe(32'(BTN_PULSE));
        expect_val("rst_mode", 0);          observe(32'(MODE));
        expect_val("rst_mode_pending", 0);  observe(32'(MODE_PENDING));
        expect_val("rst_cpu_reset", 1);     observe(32'(CPU_RESET));
        expect_val("rst_rx_out", 32'(rx_model(0, 1'b1))); observe(32'(rx_out));
        RST = 1'b0;
        tick(2);

        // Bouncy press on BTN[2], then a stable high level.
        pulses   = 0;
        rise_at  = -1;
        pulse_at = -1;
        for (int i = 0; i < BOUNCES; i++) begin
            BTN[2] = ~BTN[2];
            tick(1);
            pulses += int'(BTN_PULSE[2]);
        end
        BTN[2] = 1'b1;
        expect_val("db2_rise_tick", DB_LAT);
        expect_val("pulse2_tick", DB_LAT + 1);
        expect_val("pulse2_count", 1);
        for (int i = 1; i <= DB_LAT + 6; i++) begin
            tick(1);
            if (DB_BTN[2] && rise_at < 0) rise_at = i;
            if (BTN_PULSE[2]) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        observe(32'(rise_at));
        observe(32'(pulse_at));
        observe(32'(pulses));

        // Reset sequencing against calibration.
        expect_val("cpu_reset_no_calib", 1); observe(32'(CPU_RESET));
        init_calib_complete = 1'b1;
        tick(RST_HOLD + 1);
        expect_val("cpu_reset_hold_last", 1); observe(32'(CPU_RESET));
        tick(1);
        expect_val("cpu_reset_release", 0); observe(32'(CPU_RESET));
        init_calib_complete = 1'b0;
        tick(1);
        expect_val("cpu_reset_calib_drop", 1); observe(32'(CPU_RESET));
        init_calib_complete = 1'b1;
        tick(RST_HOLD + 2);
        expect_val("cpu_reset_rerelease", 0); observe(32'(CPU_RESET));

        // Reset button while running.
        BTN[1] = 1'b1;
        tick(DB_LAT + 1);
        expect_val("rst_btn_pulse", 1);      observe(32'(BTN_PULSE[1]));
        expect_val("cpu_reset_pre_btn", 0);  observe(32'(CPU_RESET));
        tick(1);
        expect_val("cpu_reset_btn", 1);      observe(32'(CPU_RESET));
        tick(RST_HOLD);
        expect_val("cpu_reset_btn_hold", 1); observe(32'(CPU_RESET));
        tick(1);
        expect_val("cpu_reset_btn_done", 0); observe(32'(CPU_RESET));
        BTN[1] = 1'b0;
        tick(DB_LAT + 3);
        expect_val("cpu_reset_btn_release", 0); observe(32'(CPU_RESET));

        // Mode request while mode 0 keeps transmitting.
        tx_in = 3'b110;
        srx   = 1'b0;
        BTN[0] = 1'b1;
        for (int i = 0; i < DB_LAT + 2; i++) begin
            tx_in[0] = ~tx_in[0];
            tick(1);
        end
        tx_in[0] = 1'b0;
        tick(1);
        expect_val("pending_set", 1);   observe(32'(MODE_PENDING));
        expect_val("mode_held", 0);     observe(32'(MODE));
        expect_val("stx_mode0", 0);     observe(32'(stx));
        expect_val("rx_mode0", 32'(rx_model(0, 1'b0))); observe(32'(rx_out));
        tx_in[0] = 1'b1;
        tick(IDLE_CYCLES - 1);
        expect_val("mode_before_idle", 0); observe(32'(MODE));
        expect_val("pending_before_idle", 1); observe(32'(MODE_PENDING));
        tick(1);
        expect_val("mode_applied", 1);   observe(32'(MODE));
        expect_val("pending_clear", 0);  observe(32'(MODE_PENDING));
        tx_in[1] = 1'b0;
        #1;
        expect_val("stx_mode1_lo", 0);   observe(32'(stx));
        tx_in[1] = 1'b1;
        #1;
        expect_val("stx_mode1_hi", 1);   observe(32'(stx));
        expect_val("rx_mode1_srx0", 32'(rx_model(1, 1'b0))); observe(32'(rx_out));
        srx = 1'b1;
        #1;
        expect_val("rx_mode1_srx1", 32'(rx_model(1, 1'b1))); observe(32'(rx_out));
        BTN[0] = 1'b0;
        tick(DB_LAT + 2);

        // Two presses from mode 1 wrap straight to mode 0.
        tx_in = 3'b101;
        press_mode();
        press_mode();
        expect_val("wrap_pending", 1); observe(32'(MODE_PENDING));
        expect_val("wrap_mode_held", 1); observe(32'(MODE));
        tx_in = 3'b111;
        tick(IDLE_CYCLES);
        expect_val("wrap_mode", 0); observe(32'(MODE));

        // Two presses from mode 0 jump straight to mode 2.
        tx_in = 3'b110;
        press_mode();
        press_mode();
        tx_in = 3'b111;
        tick(IDLE_CYCLES - 1);
        expect_val("skip_mode_before", 0); observe(32'(MODE));
        tick(1);
        expect_val("skip_mode", 2); observe(32'(MODE));
        tx_in = 3'b011;
        #1;
        expect_val("stx_mode2", 0); observe(32'(stx));

        // Board reset during a pending switch.
        press_mode();
        expect_val("pending_before_rst", 1); observe(32'(MODE_PENDING));
        RST = 1'b1;
        #1;
        expect_val("rst_mid_mode", 0);      observe(32'(MODE));
        expect_val("rst_mid_pending", 0);   observe(32'(MODE_PENDING));
        expect_val("rst_mid_cpu_reset", 1); observe(32'(CPU_RESET));
        tick(2);
        RST = 1'b0;
        tx_in = 3'b111;
        tick(IDLE_CYCLES + 2);
        expect_val("post_rst_mode", 0);    observe(32'(MODE));
        expect_val("post_rst_pending", 0); observe(32'(MODE_PENDING));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
